cache_stats_monitor: RTL and testbench

- Performance monitor that sits directly downstream of a cache system (direct-mapped, 2-way or 4-way).
- Observes each read request and the L1/L2 hit flags the cache returns.
- Classifies every access as L1 hit, L2 hit or memory miss, and keeps saturating counters plus a weighted latency sum.
- Replaces ad-hoc bench-side counting with synthesizable hardware statistics.

---
 rtl/cache_stats_pkg.sv | 15 +
 rtl/seq_divider.sv | 61 ++++++
 rtl/cache_stats_monitor.sv | 177 +++++++++++++++++
 tb/tb_cache_stats_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared FSM/access-class types and default latency weights for cache_stats_monitor.
package cache_stats_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef enum logic [1:0] {CLS_L1, CLS_L2, CLS_MISS} cls_t;

  localparam int DEF_L1_LAT  = 1;
  localparam int DEF_L2_LAT  = 10;
  localparam int DEF_MEM_LAT = 100;

  // Wide enough for RESP_DELAY up to 15.
  localparam int DLY_W = 4;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider: one quotient bit per cycle, start/done handshake.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  dsr;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [W:0]    shifted;
  logic [W-1:0]  diff;

  // The quotient register doubles as the dividend shifter.
  always_comb begin
    shifted = {rem, quotient[W-1]};
    diff    = shifted[W-1:0] - dsr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        dsr      <= divisor;
        quotient <= dividend;
        cnt      <= CW'(W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (shifted >= {1'b0, dsr}) begin
          rem      <= diff;
          quotient <= {quotient[W-2:0], 1'b1};
        end else begin
          rem      <= shifted[W-1:0];
          quotient <= {quotient[W-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_stats_monitor.sv
// Cache access classifier with saturating hit/miss counters and weighted latency sum.
// Define CACHE_STATS_AVG_EN to add the Q8.8 average-latency outputs (amat_q8/amat_valid).
module cache_stats_monitor
  import cache_stats_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int SUM_W      = 24,
  parameter int L1_LAT     = DEF_L1_LAT,
  parameter int L2_LAT     = DEF_L2_LAT,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int RESP_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic             l1_hit,
  input  logic             l2_hit,
  input  logic             clear,
  output logic [CNT_W-1:0] access_count,
  output logic [CNT_W-1:0] l1_count,
  output logic [CNT_W-1:0] l2_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [SUM_W-1:0] latency_sum,
  output logic             sat,
  output logic             busy
`ifdef CACHE_STATS_AVG_EN
  ,
  output logic [15:0]      amat_q8,
  output logic             amat_valid
`endif
);
  localparam logic [DLY_W-1:0] RELOAD = DLY_W'(RESP_DELAY - 1);

  state_t           state;
  logic [DLY_W-1:0] delay_cnt;
  logic             sample;
  cls_t             cls;
  logic [SUM_W:0]   lat_add;
  logic [SUM_W:0]   sum_next;
  logic             class_full;
  logic             sum_ovf;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign sample = (state == WAIT) && (delay_cnt == '0);

  // Classification priority: L1, then L2, then memory.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cls        = CLS_MISS;
    lat_add    = (SUM_W+1)'(MEM_LAT);
    class_full = (miss_count == '1);
    if (l1_hit) begin
      cls        = CLS_L1;
      lat_add    = (SUM_W+1)'(L1_LAT);
      class_full = (l1_count == '1);
    end else if (l2_hit) begin
      cls        = CLS_L2;
      lat_add    = (SUM_W+1)'(L2_LAT);
      class_full = (l2_count == '1);
    end
    sum_next = {1'b0, latency_sum} + lat_add;
    sum_ovf  = sum_next[SUM_W];
  end

  // clear behaves like reset for the statistics and aborts any outstanding request.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state        <= IDLE;
      delay_cnt    <= '0;
      busy         <= 1'b0;
      access_count <= '0;
      l1_count     <= '0;
      l2_count     <= '0;
      miss_count   <= '0;
      drop_count   <= '0;
      latency_sum  <= '0;
      sat          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            state     <= WAIT;
            delay_cnt <= RELOAD;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (sample) begin
            access_count <= sat_inc(access_count);
            case (cls)
              CLS_L1:  l1_count   <= sat_inc(l1_count);
              CLS_L2:  l2_count   <= sat_inc(l2_count);
              default: miss_count <= sat_inc(miss_count);
            endcase
            latency_sum <= sum_ovf ? '1 : sum_next[SUM_W-1:0];
            if ((access_count == '1) || class_full || sum_ovf) sat <= 1'b1;
            // A read on the sample cycle is accepted back-to-back.
            if (read) begin
              delay_cnt <= RELOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            delay_cnt <= delay_cnt - DLY_W'(1);
            if (read) begin
              drop_count <= sat_inc(drop_count);
              if (drop_count == '1) sat <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_AVG_EN
  localparam int DW = SUM_W + 8;

  logic          upd_q;
  logic          div_start;
  logic          div_done;
  logic          div_run;
  logic          div_pend;
  logic          div_zero;
  logic [DW-1:0] div_q;

  // upd_q marks the cycle in which freshly updated counters are visible.
  always_ff @(posedge clk) begin
    if (rst || clear) upd_q <= 1'b0;
    else              upd_q <= sample;
  end

  assign div_start = !clear && (upd_q || div_pend) && (!div_run || div_done);

  seq_divider #(.W(DW)) u_div (
    .clk      (clk),
    .rst      (rst || clear),
    .start    (div_start),
    .dividend ({latency_sum, 8'h00}),
    .divisor  (DW'(access_count)),
    .quotient (div_q),
    .done     (div_done)
  );

  // Updates landing mid-divide collapse into a single follow-up divide.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_run    <= 1'b0;
      div_pend   <= 1'b0;
      div_zero   <= 1'b0;
      amat_q8    <= '0;
      amat_valid <= 1'b0;
    end else if (div_start) begin
      div_run    <= 1'b1;
      div_pend   <= 1'b0;
      div_zero   <= (access_count == '0);
      amat_valid <= 1'b0;
    end else begin
      if (upd_q) div_pend <= 1'b1;
      if (div_done) begin
        div_run    <= 1'b0;
        amat_valid <= 1'b1;
        if (div_zero)                  amat_q8 <= '0;
        else if (div_q > DW'(16'hFFFF)) amat_q8 <= 16'hFFFF;
        else                           amat_q8 <= div_q[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_stats_monitor.sv
// Scoreboard bench for cache_stats_monitor: three instances (RESP_DELAY=1, RESP_DELAY=3, SUM_W=8).
module tb_cache_stats_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd [3];
  logic        h1 [3];
  logic        h2 [3];
  logic        clr[3];
  logic [15:0] acc[3], l1c[3], l2c[3], mc[3], dc[3];
  logic        sat[3], bsy[3];
  logic [23:0] sum0, sum1;
  logic [7:0]  sum2;
  logic [15:0] amat[3];
  logic        amat_v[3];

  cache_stats_monitor u_a (
    .clk(clk), .rst(rst), .read(rd[0]), .l1_hit(h1[0]), .l2_hit(h2[0]), .clear(clr[0]),
    .access_count(acc[0]), .l1_count(l1c[0]), .l2_count(l2c[0]), .miss_count(mc[0]),
    .drop_count(dc[0]), .latency_sum(sum0), .sat(sat[0]), .busy(bsy[0])
`ifdef CACHE_STATS_AVG_EN
    , .amat_q8(amat[0]), .amat_valid(amat_v[0])
`endif
  );

  cache_stats_monitor #(.RESP_DELAY(3)) u_b (
    .clk(clk), .rst(rst), .read(rd[1]), .l1_hit(h1[1]), .l2_hit(h2[1]), .clear(clr[1]),
    .access_count(acc[1]), .l1_count(l1c[1]), .l2_count(l2c[1]), .miss_count(mc[1]),
    .drop_count(dc[1]), .latency_sum(sum1), .sat(sat[1]), .busy(bsy[1])
`ifdef CACHE_STATS_AVG_EN
    , .amat_q8(amat[1]), .amat_valid(amat_v[1])
`endif
  );

  cache_stats_monitor #(.SUM_W(8)) u_c (
    .clk(clk), .rst(rst), .read(rd[2]), .l1_hit(h1[2]), .l2_hit(h2[2]), .clear(clr[2]),
    .access_count(acc[2]), .l1_count(l1c[2]), .l2_count(l2c[2]), .miss_count(mc[2]),
    .drop_count(dc[2]), .latency_sum(sum2), .sat(sat[2]), .busy(bsy[2])
`ifdef CACHE_STATS_AVG_EN
    , .amat_q8(amat[2]), .amat_valid(amat_v[2])
`endif
  );

  typedef struct {
    string name;
    int    inst;
    int    due;
    int    acc, l1, l2, miss, drop, sum, sat, busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic step(input int i, input logic r, input logic a, input logic b, input logic c);
    rd[i] = r; h1[i] = a; h2[i] = b; clr[i] = c;
    @(posedge clk);
    #1;
    rd[i] = 1'b0; h1[i] = 1'b0; h2[i] = 1'b0; clr[i] = 1'b0;
  endtask

  task automatic expect_st(input string name, input int i, input int a, input int l1,
                           input int l2, input int m, input int d, input int s,
                           input int st, input int b);
    exp_t e;
    e.name = name; e.inst = i; e.due = cyc;
    e.acc = a; e.l1 = l1; e.l2 = l2; e.miss = m; e.drop = d; e.sum = s; e.sat = st; e.busy = b;
    sb.push_back(e);
  endtask

  // Monitor: pops every expectation that has come due and compares against the live outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] s;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.inst)
        0:       s = {8'h00, sum0};
        1:       s = {8'h00, sum1};
        default: s = {24'h0, sum2};
      endcase
      check($sformatf("%s.access", e.name), {16'h0, acc[e.inst]}, e.acc);
      check($sformatf("%s.l1", e.name),     {16'h0, l1c[e.inst]}, e.l1);
      check($sformatf("%s.l2", e.name),     {16'h0, l2c[e.inst]}, e.l2);
      check($sformatf("%s.miss", e.name),   {16'h0, mc[e.inst]},  e.miss);
      check($sformatf("%s.drop", e.name),   {16'h0, dc[e.inst]},  e.drop);
      check($sformatf("%s.sum", e.name),    s,                    e.sum);
      check($sformatf("%s.sat", e.name),    {31'h0, sat[e.inst]}, e.sat);
      check($sformatf("%s.busy", e.name),   {31'h0, bsy[e.inst]}, e.busy);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; h1[i] = 1'b0; h2[i] = 1'b0; clr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) expect_st("reset", i, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // L1, L2, miss with single-cycle response.
    step(0, 1, 0, 0, 0); expect_st("accept", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0); expect_st("l1", 0, 1, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0); expect_st("l2", 0, 2, 1, 1, 0, 0, 11, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); expect_st("miss", 0, 3, 1, 1, 1, 0, 111, 0, 0);

`ifdef CACHE_STATS_AVG_EN
    k = 0;
    while (!amat_v[0] && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("amat_valid", {31'h0, amat_v[0]}, 1);
    check("amat_q8", {16'h0, amat[0]}, 32'h2500);
`endif

    // Both flags set: L1 wins.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0); expect_st("both_flags", 0, 4, 2, 1, 1, 0, 112, 0, 0);

    // clear with a same-cycle read: stats zeroed, read ignored.
    step(0, 1, 0, 0, 1); expect_st("clear_read", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // clear on the sample cycle beats the update.
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0); expect_st("pre_clear", 0, 1, 0, 1, 0, 0, 10, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1); expect_st("clear_sample", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0); expect_st("clear_abort", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst mid-request discards it.
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); expect_st("pre_rst", 0, 1, 0, 0, 1, 0, 100, 0, 0);
    step(0, 1, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 1, 0, 0); expect_st("rst_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0); expect_st("post_rst", 0, 1, 1, 0, 0, 0, 1, 0, 0);

    // RESP_DELAY=3: reads at cycles 0, 1, 3.
    step(1, 1, 0, 0, 0); expect_st("d3_accept", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0); expect_st("d3_drop", 1, 0, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0); expect_st("d3_b2b", 1, 1, 1, 0, 0, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0); expect_st("d3_done", 1, 2, 1, 1, 0, 1, 11, 0, 0);

    // SUM_W=8: third miss clamps the accumulator at 255.
    for (int n = 0; n < 2; n++) begin
      step(2, 1, 0, 0, 0);
      step(2, 0, 0, 0, 0);
    end
    expect_st("sum_200", 2, 2, 0, 0, 2, 0, 200, 0, 0);
    step(2, 1, 0, 0, 0);
    step(2, 0, 0, 0, 0); expect_st("sum_clamp", 2, 3, 0, 0, 3, 0, 255, 1, 0);
    step(2, 0, 0, 0, 1); expect_st("sum_clear", 2, 0, 0, 0, 0, 0, 0, 0, 0);

    // Counter saturation with continuous back-to-back L1 hits.
    step(0, 0, 0, 0, 1);
    for (int n = 0; n < 65536; n++) step(0, 1, 1, 0, 0);
    expect_st("cnt_full", 0, 32'hFFFF, 32'hFFFF, 0, 0, 0, 32'hFFFF, 0, 1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0); expect_st("cnt_sat", 0, 32'hFFFF, 32'hFFFF, 0, 0, 0, 65538, 1, 0);
    step(0, 0, 0, 0, 1); expect_st("sat_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
